// File: rtl/conv_16_18_div_seq.sv
// Sequential signed divider: 24-bit accumulator / 8-bit divisor -> 16-bit saturated quotient + remainder.
// Radix-2 restoring iteration on magnitudes, fixed latency, valid/ready on both sides.
module conv_16_18_div_seq #(
   parameter int DIVIDEND_WIDTH = 24,
   parameter int DIVISOR_WIDTH  = 8,
   parameter int QUOTIENT_WIDTH = 16
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      ovf,
   output logic                      div_zero
);
   localparam int DW = DIVIDEND_WIDTH;
   localparam int VW = DIVISOR_WIDTH;
   localparam int QW = QUOTIENT_WIDTH;
   localparam int CW = $clog2(DW + 1);

   localparam logic signed [DW:0] Q_MAX = {{(DW-QW+1){1'b0}}, 1'b0, {(QW-1){1'b1}}};
   localparam logic signed [DW:0] Q_MIN = {{(DW-QW+1){1'b1}}, 1'b1, {(QW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;

   // r_work starts as |dividend| and ends as the raw quotient: each step shifts
   // one dividend bit out of the top and one quotient bit in at the bottom.
   logic [DW-1:0]   r_work;
   logic [VW-1:0]   r_dvs;
   logic [VW-1:0]   r_prem;
   logic [CW-1:0]   r_count;
   logic            r_dvd_neg;
   logic            r_dvs_neg;
   logic            r_dz;

   logic            r_out_valid;
   logic [QW-1:0]   r_quotient;
   logic [VW-1:0]   r_remainder;
   logic            r_ovf;
   logic            r_div_zero;

   logic [DW-1:0]   w_dvd_mag;
   logic [VW-1:0]   w_dvs_mag;
   logic [VW:0]     w_shift;
   logic            w_ge;
   logic [VW-1:0]   w_diff;
   logic [VW-1:0]   w_prem_next;
   logic [DW:0]     w_q_val;
   logic [QW-1:0]   w_q_sat;
   logic            w_q_ovf;
   logic [VW-1:0]   w_rem;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign ovf       = r_ovf;
   assign div_zero  = r_div_zero;

   assign w_dvd_mag = dividend[DW-1] ? ({DW{1'b0}} - dividend) : dividend;
   assign w_dvs_mag = divisor[VW-1]  ? ({VW{1'b0}} - divisor)  : divisor;

   // The partial remainder stays below |divisor| <= 2^(VW-1), so the
   // difference fits in VW bits and modulo-2^VW subtraction is exact.
   assign w_shift     = {r_prem, r_work[DW-1]};
   assign w_ge        = (w_shift >= {1'b0, r_dvs});
   assign w_diff      = w_shift[VW-1:0] - r_dvs;
   assign w_prem_next = w_ge ? w_diff : w_shift[VW-1:0];

   assign w_q_val = (r_dvd_neg ^ r_dvs_neg) ? ({(DW+1){1'b0}} - {1'b0, r_work})
                                            : {1'b0, r_work};

   always_comb begin
      w_q_sat = w_q_val[QW-1:0];
      w_q_ovf = 1'b0;
      if ($signed(w_q_val) > Q_MAX) begin
         w_q_sat = {1'b0, {(QW-1){1'b1}}};
         w_q_ovf = 1'b1;
      end else if ($signed(w_q_val) < Q_MIN) begin
         w_q_sat = {1'b1, {(QW-1){1'b0}}};
         w_q_ovf = 1'b1;
      end
   end

   assign w_rem = r_dvd_neg ? ({VW{1'b0}} - r_prem) : r_prem;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_next = S_CALC;
         S_CALC:  if (r_count == CW'(1)) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_work      <= '0;
         r_dvs       <= '0;
         r_prem      <= '0;
         r_count     <= '0;
         r_dvd_neg   <= 1'b0;
         r_dvs_neg   <= 1'b0;
         r_dz        <= 1'b0;
         r_out_valid <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_ovf       <= 1'b0;
         r_div_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work    <= w_dvd_mag;
                  r_dvs     <= w_dvs_mag;
                  r_prem    <= '0;
                  r_count   <= CW'(DW);
                  r_dvd_neg <= dividend[DW-1];
                  r_dvs_neg <= divisor[VW-1];
                  r_dz      <= (divisor == '0);
               end
            end
            S_CALC: begin
               r_prem  <= w_prem_next;
               r_work  <= {r_work[DW-2:0], w_ge};
               r_count <= r_count - 1'b1;
            end
            S_FIX: begin
               r_out_valid <= 1'b1;
               if (r_dz) begin
                  r_quotient  <= r_dvd_neg ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
                  r_remainder <= '0;
                  r_ovf       <= 1'b0;
                  r_div_zero  <= 1'b1;
               end else begin
                  r_quotient  <= w_q_sat;
                  r_remainder <= w_rem;
                  r_ovf       <= w_q_ovf;
                  r_div_zero  <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_16_18_div_seq.sv
// Directed-vector bench for conv_16_18_div_seq: table of signed divisions, backpressure,
// mid-operation reset and a random sweep against integer division.
module tb_conv_16_18_div_seq;
   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        ovf;
   logic        div_zero;

   int n_checks = 0;
   int n_err = 0;

   typedef struct {
      logic signed [23:0] a;
      logic signed [7:0]  b;
      logic signed [15:0] q;
      logic signed [7:0]  r;
      logic               o;
      logic               z;
   } vec_t;

   vec_t vecs[16];

   conv_16_18_div_seq dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .div_zero  (div_zero)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Assumes in_ready=1 and out_ready=1 on entry; leaves the block back in IDLE.
   task automatic run_op(input logic signed [23:0] a, input logic signed [7:0] b,
                         input logic signed [15:0] eq, input logic signed [7:0] er,
                         input logic eo, input logic ez, input string tag);
      int lat;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      check({tag, ".in_ready_busy"}, in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      check({tag, ".latency"}, lat, 25);
      check({tag, ".q"}, $signed(quotient), eq);
      check({tag, ".r"}, $signed(remainder), er);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".div_zero"}, div_zero, ez);
      $display("op %s: %0d / %0d -> q=%0d r=%0d ovf=%0d dz=%0d lat=%0d", tag, a, b,
               $signed(quotient), $signed(remainder), ovf, div_zero, lat);
      @(posedge ap_clk); #1;
      check({tag, ".out_valid_drop"}, out_valid, 0);
      check({tag, ".in_ready_back"}, in_ready, 1);
   endtask

   task automatic model(input longint a, input longint b, output logic signed [15:0] q,
                        output logic signed [7:0] r, output logic o, output logic z);
      longint t;
      if (b == 0) begin
         z = 1'b1;
         o = 1'b0;
         r = '0;
         q = (a >= 0) ? 16'sh7FFF : 16'sh8000;
      end else begin
         z = 1'b0;
         t = a / b;
         r = 8'(a % b);
         o = 1'b1;
         if (t > 32767)       q = 16'sh7FFF;
         else if (t < -32768) q = 16'sh8000;
         else begin
            q = 16'(t);
            o = 1'b0;
         end
      end
   endtask

   initial begin
      logic signed [23:0] ra;
      logic signed [7:0]  rb;
      logic signed [15:0] mq;
      logic signed [7:0]  mr;
      logic               mo;
      logic               mz;
      int                 lat;

      vecs[0]  = '{24'sd1000,    8'sd7,    16'sd142,    8'sd6,    1'b0, 1'b0};
      vecs[1]  = '{-24'sd1000,   8'sd7,    -16'sd142,   -8'sd6,   1'b0, 1'b0};
      vecs[2]  = '{24'sd1000,    -8'sd7,   -16'sd142,   8'sd6,    1'b0, 1'b0};
      vecs[3]  = '{-24'sd1000,   -8'sd7,   16'sd142,    -8'sd6,   1'b0, 1'b0};
      vecs[4]  = '{24'sd0,       8'sd5,    16'sd0,      8'sd0,    1'b0, 1'b0};
      vecs[5]  = '{24'sh7FFFFF,  8'sd1,    16'sh7FFF,   8'sd0,    1'b1, 1'b0};
      vecs[6]  = '{24'sh800000,  8'sh80,   16'sh7FFF,   8'sd0,    1'b1, 1'b0};
      vecs[7]  = '{24'sh800000,  8'sd1,    16'sh8000,   8'sd0,    1'b1, 1'b0};
      vecs[8]  = '{24'sd98301,   8'sd3,    16'sh7FFF,   8'sd0,    1'b0, 1'b0};
      vecs[9]  = '{-24'sd98304,  8'sd3,    16'sh8000,   8'sd0,    1'b0, 1'b0};
      vecs[10] = '{24'sd98304,   8'sd3,    16'sh7FFF,   8'sd0,    1'b1, 1'b0};
      vecs[11] = '{24'sd500,     8'sd0,    16'sh7FFF,   8'sd0,    1'b0, 1'b1};
      vecs[12] = '{-24'sd500,    8'sd0,    16'sh8000,   8'sd0,    1'b0, 1'b1};
      vecs[13] = '{24'sh7FFFFF,  8'sh80,   16'sh8000,   8'sd127,  1'b1, 1'b0};
      vecs[14] = '{24'sd127,     8'sh80,   16'sd0,      8'sd127,  1'b0, 1'b0};
      vecs[15] = '{-24'sd255,    8'sh80,   16'sd1,      -8'sd127, 1'b0, 1'b0};

      // Reset state
      #12;
      check("rst.in_ready", in_ready, 1);
      check("rst.out_valid", out_valid, 0);
      check("rst.q", quotient, 0);
      check("rst.r", remainder, 0);
      check("rst.ovf", ovf, 0);
      check("rst.div_zero", div_zero, 0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z,
                $sformatf("vec%0d", i));
      end

      // Backpressure: result must hold while out_ready=0, new operands ignored
      out_ready = 1'b0;
      dividend = 24'sd1000;
      divisor  = 8'sd7;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      check("bp.latency", lat, 25);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = 24'($urandom);
         divisor  = 8'($urandom);
         @(posedge ap_clk); #1;
         check("bp.out_valid_hold", out_valid, 1);
         check("bp.q_hold", $signed(quotient), 142);
         check("bp.r_hold", $signed(remainder), 6);
         check("bp.in_ready_low", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      $display("op bp: 1000 / 7 held 10 cycles -> q=%0d r=%0d", $signed(quotient), $signed(remainder));
      @(posedge ap_clk); #1;
      check("bp.out_valid_drop", out_valid, 0);
      check("bp.in_ready_back", in_ready, 1);
      check("bp.q_kept", $signed(quotient), 142);
      run_op(24'sd77, -8'sd8, -16'sd9, 8'sd5, 1'b0, 1'b0, "bp_next");

      // Reset in the middle of CALC
      dividend = 24'sd5000;
      divisor  = 8'sd3;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b0;
      #1;
      check("mrst.out_valid", out_valid, 0);
      check("mrst.q", quotient, 0);
      check("mrst.r", remainder, 0);
      check("mrst.in_ready", in_ready, 1);
      $display("op mrst: reset asserted mid-CALC");
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      check("mrst.out_valid_after", out_valid, 0);
      run_op(24'sd100, 8'sd10, 16'sd10, 8'sd0, 1'b0, 1'b0, "mrst_next");

      // Random sweep against integer division
      for (int i = 0; i < 1000; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 24'($signed(12'($urandom))) : 24'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? 8'sd0 : 8'($urandom);
         model(longint'(ra), longint'(rb), mq, mr, mo, mz);
         run_op(ra, rb, mq, mr, mo, mz, $sformatf("rnd%0d", i));
         if (!mo && !mz) begin
            check($sformatf("rnd%0d.invariant", i),
                  longint'($signed(quotient)) * longint'(rb) + longint'($signed(remainder)),
                  longint'(ra));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
